// File: rtl/turn_scheduler.sv
// Turn sequencer: active player selection, per-turn step timer, round counting,
// keyboard-to-game-logic operation forwarding and game-end detection.
// Optional macro STEP_TIMER_EN enables the prescaler and per-turn timeout.
module turn_scheduler #(
  parameter int unsigned MAX_PLAYER_CNT      = 7,
  parameter int unsigned LOG2_MAX_PLAYER_CNT = 3,
  parameter int unsigned MAX_STEP_TIME       = 15,
  parameter int unsigned LOG2_MAX_STEP_TIME  = 4,
  parameter int unsigned LOG2_MAX_ROUND      = 12,
  parameter int unsigned TICKS_PER_SEC       = 50000000
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic                           start,
  input  logic [MAX_PLAYER_CNT-1:0]      alive_mask,
  input  logic                           keyboard_ready,
  input  logic [2:0]                     keyboard_data,
  input  logic                           op_ack,
  output logic                           keyboard_read_fin,
  output logic                           op_valid,
  output logic [2:0]                     op_data,
  output logic [LOG2_MAX_PLAYER_CNT-1:0] current_player,
  output logic [LOG2_MAX_PLAYER_CNT-1:0] next_player,
  output logic [LOG2_MAX_STEP_TIME-1:0]  step_timer,
  output logic [LOG2_MAX_ROUND-1:0]      round,
  output logic                           turn_start,
  output logic                           game_over,
  output logic [LOG2_MAX_PLAYER_CNT-1:0] winner
);

  localparam int unsigned PW = LOG2_MAX_PLAYER_CNT;
  localparam int unsigned SW = LOG2_MAX_STEP_TIME;
  localparam int unsigned RW = LOG2_MAX_ROUND;
  localparam logic [2:0]  END_TURN = 3'b111;

  typedef enum logic [2:0] {IDLE, TURN_START, WAIT_OP, FORWARD, OVER} state_t;

  state_t          state, state_d;
  logic [PW-1:0]   cur_d, winner_d, lowest, above, alive_cnt, over_winner;
  logic [RW-1:0]   round_d;
  logic [SW-1:0]   timer_d;
  logic [2:0]      op_data_d;
  logic            op_valid_d, read_fin_d, turn_start_d, game_over_d;
  logic            few_alive, wrap, key_avail, expire, adv;

  // The decoder drops ready one cycle after read_fin; never consume a key twice.
  assign key_avail = keyboard_ready && !keyboard_read_fin;

  // Cyclic search for the next alive ID above current, else the lowest alive ID.
  always_comb begin
    above     = '0;
    lowest    = '0;
    alive_cnt = '0;
    for (int c = MAX_PLAYER_CNT; c >= 1; c--) begin
      if (alive_mask[c-1]) begin
        lowest    = PW'(c);
        alive_cnt = alive_cnt + PW'(1);
        if (PW'(c) > current_player) above = PW'(c);
      end
    end
    next_player = (above != '0) ? above : lowest;
  end

  assign few_alive   = alive_cnt <= PW'(1);
  assign over_winner = (alive_cnt == PW'(1)) ? lowest : '0;
  assign wrap        = next_player <= current_player;

`ifdef STEP_TIMER_EN
  localparam int unsigned PRE_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic             pend_q, pend_d, run, tick;

  assign run    = (state == WAIT_OP) || (state == FORWARD);
  assign tick   = run && (pre_q == PRE_W'(TICKS_PER_SEC - 1));
  // A timeout seen during FORWARD is remembered and honoured after the ack.
  assign expire = (tick && (step_timer == '0)) || pend_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pre_q  <= '0;
      pend_q <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      pend_q <= pend_d;
    end
  end
`else
  localparam int unsigned unused_ticks = TICKS_PER_SEC;
  assign expire = 1'b0;
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state;
    cur_d        = current_player;
    round_d      = round;
    timer_d      = step_timer;
    op_valid_d   = op_valid;
    op_data_d    = op_data;
    read_fin_d   = 1'b0;
    turn_start_d = 1'b0;
    game_over_d  = game_over;
    winner_d     = winner;
    adv          = 1'b0;
`ifdef STEP_TIMER_EN
    pre_d  = pre_q;
    pend_d = pend_q;
    if (tick) begin
      pre_d = '0;
      if (step_timer != '0) timer_d = step_timer - SW'(1);
    end else if (run) begin
      pre_d = pre_q + PRE_W'(1);
    end
`endif
    case (state)
      IDLE: begin
        read_fin_d = key_avail;
        if (start) begin
          if (few_alive) begin
            state_d     = OVER;
            game_over_d = 1'b1;
            winner_d    = over_winner;
            cur_d       = '0;
          end else begin
            cur_d        = next_player;
            round_d      = '0;
            state_d      = TURN_START;
            turn_start_d = 1'b1;
          end
        end
      end
      TURN_START: begin
        timer_d = SW'(MAX_STEP_TIME);
`ifdef STEP_TIMER_EN
        pre_d  = '0;
        pend_d = 1'b0;
`endif
        state_d = WAIT_OP;
      end
      WAIT_OP: begin
        if (few_alive) begin
          state_d     = OVER;
          game_over_d = 1'b1;
          winner_d    = over_winner;
          cur_d       = '0;
        end else if (expire) begin
          adv = 1'b1;
        end else if (key_avail) begin
          read_fin_d = 1'b1;
          if (keyboard_data == END_TURN) begin
            adv = 1'b1;
          end else begin
            op_valid_d = 1'b1;
            op_data_d  = keyboard_data;
            state_d    = FORWARD;
          end
        end
      end
      FORWARD: begin
`ifdef STEP_TIMER_EN
        if (tick && (step_timer == '0)) pend_d = 1'b1;
`endif
        if (op_ack) begin
          op_valid_d = 1'b0;
          state_d    = WAIT_OP;
        end
      end
      OVER: begin
        read_fin_d = key_avail;
        cur_d      = '0;
      end
      default: state_d = IDLE;
    endcase

    // Turn advance; a wrap with a saturated round counter ends the game.
    if (adv) begin
      if (wrap && (round == '1)) begin
        state_d     = OVER;
        game_over_d = 1'b1;
        winner_d    = '0;
        cur_d       = '0;
      end else begin
        cur_d        = next_player;
        if (wrap) round_d = round + RW'(1);
        state_d      = TURN_START;
        turn_start_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state             <= IDLE;
      current_player    <= '0;
      round             <= '0;
      step_timer        <= SW'(MAX_STEP_TIME);
      op_valid          <= 1'b0;
      op_data           <= '0;
      keyboard_read_fin <= 1'b0;
      turn_start        <= 1'b0;
      game_over         <= 1'b0;
      winner            <= '0;
    end else begin
      state             <= state_d;
      current_player    <= cur_d;
      round             <= round_d;
      step_timer        <= timer_d;
      op_valid          <= op_valid_d;
      op_data           <= op_data_d;
      keyboard_read_fin <= read_fin_d;
      turn_start        <= turn_start_d;
      game_over         <= game_over_d;
      winner            <= winner_d;
    end
  end

endmodule

// File: tb/tb_turn_scheduler.sv
// Self-checking bench for turn_scheduler: scenario tasks with queued expectations.
module tb_turn_scheduler;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       start;
  logic [6:0] alive_mask;
  logic       keyboard_ready;
  logic [2:0] keyboard_data;
  logic       op_ack;
  logic       keyboard_read_fin, op_valid, turn_start, game_over;
  logic [2:0] op_data, current_player, next_player, winner;
  logic [3:0] step_timer;
  logic [1:0] round;

  typedef struct packed {
    logic [2:0] player;
    logic [1:0] rnd;
  } turn_t;

  turn_t      turn_q[$];
  logic [2:0] op_q[$];
  int         total = 0;
  int         bad   = 0;

  turn_scheduler #(
    .MAX_PLAYER_CNT(7), .LOG2_MAX_PLAYER_CNT(3), .MAX_STEP_TIME(15),
    .LOG2_MAX_STEP_TIME(4), .LOG2_MAX_ROUND(2), .TICKS_PER_SEC(4)
  ) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .alive_mask(alive_mask),
    .keyboard_ready(keyboard_ready), .keyboard_data(keyboard_data), .op_ack(op_ack),
    .keyboard_read_fin(keyboard_read_fin), .op_valid(op_valid), .op_data(op_data),
    .current_player(current_player), .next_player(next_player), .step_timer(step_timer),
    .round(round), .turn_start(turn_start), .game_over(game_over), .winner(winner)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    reset_n = 1'b0; start = 1'b0; alive_mask = '0; keyboard_ready = 1'b0;
    keyboard_data = '0; op_ack = 1'b0;
    turn_q.delete(); op_q.delete();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic start_game(output bit ok);
    ok = 1'b0;
    @(negedge clock);
    start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (turn_start || game_over) begin ok = 1'b1; break; end
    end
    start = 1'b0;
  endtask

  task automatic press_key(input logic [2:0] code, output bit ok);
    ok = 1'b0;
    @(negedge clock);
    keyboard_ready = 1'b1;
    keyboard_data  = code;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (keyboard_read_fin) begin ok = 1'b1; break; end
    end
    keyboard_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; alive_mask = '0; keyboard_ready = 1'b0;
    keyboard_data = '0; op_ack = 1'b0;
    repeat (2) @(negedge clock);
    total++;
    if ({op_valid, keyboard_read_fin, turn_start, game_over, current_player, winner, round, next_player} !== '0) begin
      $display("FAIL reset_outputs: got %b required all zero",
               {op_valid, keyboard_read_fin, turn_start, game_over, current_player, winner, round, next_player});
      bad++;
    end
    total++;
    if (step_timer !== 4'd15) begin
      $display("FAIL reset_timer: got %0d required 15", step_timer); bad++;
    end
    reset_n = 1'b1;
  endtask

  task automatic test_idle_drain();
    bit ok;
    do_reset();
    alive_mask = 7'b0000001;
    press_key(3'b010, ok);
    total++;
    if (!ok || op_valid !== 1'b0 || current_player !== 3'd0) begin
      $display("FAIL idle_drain: read_fin=%0d op_valid=%0d cur=%0d required 1 0 0", ok, op_valid, current_player);
      bad++;
    end
    start_game(ok);
    total++;
    if (!ok || game_over !== 1'b1 || winner !== 3'd1 || current_player !== 3'd0) begin
      $display("FAIL start_one_alive: over=%0d winner=%0d cur=%0d required 1 1 0", game_over, winner, current_player);
      bad++;
    end
    do_reset();
    start_game(ok);
    total++;
    if (!ok || game_over !== 1'b1 || winner !== 3'd0) begin
      $display("FAIL start_none_alive: over=%0d winner=%0d required 1 0", game_over, winner);
      bad++;
    end
  endtask

  task automatic test_basic();
    bit ok;
    turn_t e;
    do_reset();
    alive_mask = 7'b0000111;
    start_game(ok);
    total++;
    if (!ok || turn_start !== 1'b1 || current_player !== 3'd1 || round !== 2'd0 || next_player !== 3'd2) begin
      $display("FAIL basic_start: ts=%0d cur=%0d round=%0d next=%0d required 1 1 0 2",
               turn_start, current_player, round, next_player);
      bad++;
    end
    turn_q.push_back('{player: 3'd2, rnd: 2'd0});
    press_key(3'b111, ok);
    e = turn_q.pop_front();
    total++;
    if (!ok || turn_start !== 1'b1 || current_player !== e.player || round !== e.rnd) begin
      $display("FAIL basic_end_turn: ts=%0d cur=%0d round=%0d required 1 %0d %0d",
               turn_start, current_player, round, e.player, e.rnd);
      bad++;
    end
    @(negedge clock);
    total++;
    if (turn_start !== 1'b0 || op_valid !== 1'b0) begin
      $display("FAIL basic_pulse: ts=%0d op_valid=%0d required 0 0", turn_start, op_valid); bad++;
    end
  endtask

  task automatic test_timeout();
    bit ok, ok2;
    do_reset();
    alive_mask = 7'b0000111;
    start_game(ok);
    press_key(3'b111, ok);
    press_key(3'b111, ok2);
    total++;
    if (!ok || !ok2 || current_player !== 3'd3) begin
      $display("FAIL timeout_setup: cur=%0d required 3", current_player); bad++;
    end
`ifdef STEP_TIMER_EN
    begin
      logic [15:0] seen;
      int cycles;
      seen = '0;
      cycles = 0;
      for (int i = 0; i < 200; i++) begin
        @(negedge clock);
        cycles++;
        seen[step_timer] = 1'b1;
        if (turn_start) break;
      end
      total++;
      if (cycles !== 65 || seen !== 16'hFFFF) begin
        $display("FAIL timeout_timer: cycles=%0d seen=%h required 65 ffff", cycles, seen); bad++;
      end
      total++;
      if (current_player !== 3'd1 || round !== 2'd1) begin
        $display("FAIL timeout_advance: cur=%0d round=%0d required 1 1", current_player, round); bad++;
      end
    end
`else
    repeat (100) @(negedge clock);
    total++;
    if (step_timer !== 4'd15 || current_player !== 3'd3 || turn_start !== 1'b0) begin
      $display("FAIL no_timeout: timer=%0d cur=%0d ts=%0d required 15 3 0", step_timer, current_player, turn_start);
      bad++;
    end
`endif
  endtask

  task automatic test_forward();
    bit ok, held;
    logic [2:0] e;
    do_reset();
    alive_mask = 7'b0000111;
    start_game(ok);
    op_q.push_back(3'd2);
    press_key(3'b010, ok);
    e = op_q.pop_front();
    total++;
    if (!ok || op_valid !== 1'b1 || op_data !== e) begin
      $display("FAIL fwd_issue: read_fin=%0d op_valid=%0d op_data=%0d required 1 1 %0d", ok, op_valid, op_data, e);
      bad++;
    end
    keyboard_ready = 1'b1;
    keyboard_data  = 3'b011;
    op_q.push_back(3'd3);
    held = 1'b1;
    repeat (5) begin
      @(negedge clock);
      if (op_valid !== 1'b1 || op_data !== 3'd2 || keyboard_read_fin !== 1'b0) held = 1'b0;
    end
    total++;
    if (!held) begin
      $display("FAIL fwd_hold: op_valid=%0d op_data=%0d read_fin=%0d required 1 2 0",
               op_valid, op_data, keyboard_read_fin);
      bad++;
    end
    op_ack = 1'b1;
    @(negedge clock);
    op_ack = 1'b0;
    total++;
    if (op_valid !== 1'b0 || keyboard_read_fin !== 1'b0) begin
      $display("FAIL fwd_ack: op_valid=%0d read_fin=%0d required 0 0", op_valid, keyboard_read_fin); bad++;
    end
    @(negedge clock);
    keyboard_ready = 1'b0;
    e = op_q.pop_front();
    total++;
    if (keyboard_read_fin !== 1'b1 || op_valid !== 1'b1 || op_data !== e) begin
      $display("FAIL fwd_pending_key: read_fin=%0d op_valid=%0d op_data=%0d required 1 1 %0d",
               keyboard_read_fin, op_valid, op_data, e);
      bad++;
    end
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    total++;
    if (op_valid !== 1'b0) begin
      $display("FAIL fwd_async_reset: op_valid=%0d required 0", op_valid); bad++;
    end
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_skip_dead();
    bit ok;
    turn_t e;
    do_reset();
    alive_mask = 7'b1000101;
    start_game(ok);
    total++;
    if (!ok || current_player !== 3'd1) begin
      $display("FAIL skip_start: cur=%0d required 1", current_player); bad++;
    end
    turn_q.push_back('{player: 3'd3, rnd: 2'd0});
    turn_q.push_back('{player: 3'd7, rnd: 2'd0});
    turn_q.push_back('{player: 3'd1, rnd: 2'd1});
    for (int i = 0; i < 3; i++) begin
      press_key(3'b111, ok);
      e = turn_q.pop_front();
      total++;
      if (!ok || current_player !== e.player || round !== e.rnd) begin
        $display("FAIL skip_dead[%0d]: cur=%0d round=%0d required %0d %0d", i, current_player, round, e.player, e.rnd);
        bad++;
      end
      if (i == 0) begin
        total++;
        if (next_player !== 3'd7) begin
          $display("FAIL skip_next: next=%0d required 7", next_player); bad++;
        end
      end
    end
  endtask

  task automatic test_game_over();
    bit ok, ok2, stay;
    do_reset();
    alive_mask = 7'b0000111;
    start_game(ok);
    press_key(3'b111, ok);
    press_key(3'b111, ok2);
    @(negedge clock);
    alive_mask = 7'b0000100;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      if (game_over) break;
    end
    total++;
    if (game_over !== 1'b1 || winner !== 3'd3 || current_player !== 3'd0) begin
      $display("FAIL over_enter: over=%0d winner=%0d cur=%0d required 1 3 0", game_over, winner, current_player);
      bad++;
    end
    press_key(3'b001, ok);
    total++;
    if (!ok || op_valid !== 1'b0) begin
      $display("FAIL over_drain: read_fin=%0d op_valid=%0d required 1 0", ok, op_valid); bad++;
    end
    start = 1'b1;
    alive_mask = 7'b0000111;
    stay = 1'b1;
    repeat (10) begin
      @(negedge clock);
      if (game_over !== 1'b1 || winner !== 3'd3 || turn_start !== 1'b0) stay = 1'b0;
    end
    start = 1'b0;
    total++;
    if (!stay) begin
      $display("FAIL over_sticky: over=%0d winner=%0d required 1 3", game_over, winner); bad++;
    end
    reset_n = 1'b0;
    #1;
    total++;
    if (game_over !== 1'b0 || winner !== 3'd0) begin
      $display("FAIL over_reset: over=%0d winner=%0d required 0 0", game_over, winner); bad++;
    end
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_round_limit();
    bit ok;
    turn_t e;
    do_reset();
    alive_mask = 7'b0000011;
    start_game(ok);
    for (int r = 0; r < 4; r++) begin
      turn_q.push_back('{player: 3'd2, rnd: 2'(r)});
      if (r < 3) turn_q.push_back('{player: 3'd1, rnd: 2'(r + 1)});
    end
    for (int i = 0; i < 7; i++) begin
      press_key(3'b111, ok);
      e = turn_q.pop_front();
      total++;
      if (!ok || current_player !== e.player || round !== e.rnd || game_over !== 1'b0) begin
        $display("FAIL round_step[%0d]: cur=%0d round=%0d over=%0d required %0d %0d 0",
                 i, current_player, round, game_over, e.player, e.rnd);
        bad++;
      end
    end
    press_key(3'b111, ok);
    total++;
    if (!ok || game_over !== 1'b1 || winner !== 3'd0 || current_player !== 3'd0 || round !== 2'd3) begin
      $display("FAIL round_limit: over=%0d winner=%0d cur=%0d round=%0d required 1 0 0 3",
               game_over, winner, current_player, round);
      bad++;
    end
  endtask

  initial begin
    test_reset();
    test_idle_drain();
    test_basic();
    test_timeout();
    test_forward();
    test_skip_dead();
    test_game_over();
    test_round_limit();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
